// File: rtl/cpu_core_seq_pkg.sv
// Shared types and opcode constants for the sequenced 6502-subset core.
package cpu_core_seq_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_OP1    = 4'd2,
        S_OP2    = 4'd3,
        S_MEM    = 4'd4,
        S_LOAD   = 4'd5,
        S_HALT   = 4'd6
    } state_t;

    typedef logic [15:0] addr_t;
    typedef logic [7:0]  data_t;

    localparam data_t OP_BRK   = 8'h00;
    localparam data_t OP_CLC   = 8'h18;
    localparam data_t OP_SEC   = 8'h38;
    localparam data_t OP_NOP   = 8'hEA;
    localparam data_t OP_LDA_I = 8'hA9;
    localparam data_t OP_ADC_I = 8'h69;
    localparam data_t OP_LDA_A = 8'hAD;
    localparam data_t OP_STA_A = 8'h8D;
    localparam data_t OP_JMP_A = 8'h4C;

endpackage

// File: rtl/cpu_core_seq_alu.sv
// Combinational ADC / pass-through unit with N/Z/C generation.
module cpu_alu #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              cin_i,
    input  logic              add_i,
    output logic [DATA_W-1:0] res_o,
    output logic              n_o,
    output logic              z_o,
    output logic              c_o
);

    logic [DATA_W:0] sum;

    always_comb begin
        sum = {1'b0, a_i} + {1'b0, b_i} + {{DATA_W{1'b0}}, cin_i};
        if (add_i) begin
            res_o = sum[DATA_W-1:0];
            c_o   = sum[DATA_W];
        end else begin
            res_o = b_i;
            c_o   = cin_i;
        end
        n_o = res_o[DATA_W-1];
        z_o = (res_o == '0);
    end

endmodule

// File: rtl/cpu_core_seq.sv
// Fetch/decode/execute sequencer for a 6502 opcode subset on a
// single-port synchronous memory (read data one cycle after address).
module cpu_core_seq
    import cpu_core_seq_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output state_t            state,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] acc,
    output logic [2:0]        flags,
    output logic              halted,
    output logic              illegal
);

    if (!(DATA_W < ADDR_W && ADDR_W <= 2 * DATA_W)) begin : g_bad_w
        $error("cpu_core_seq: need DATA_W < ADDR_W <= 2*DATA_W");
    end

    localparam logic [DATA_W-1:0] I_BRK   = DATA_W'(OP_BRK);
    localparam logic [DATA_W-1:0] I_CLC   = DATA_W'(OP_CLC);
    localparam logic [DATA_W-1:0] I_SEC   = DATA_W'(OP_SEC);
    localparam logic [DATA_W-1:0] I_NOP   = DATA_W'(OP_NOP);
    localparam logic [DATA_W-1:0] I_LDA_I = DATA_W'(OP_LDA_I);
    localparam logic [DATA_W-1:0] I_ADC_I = DATA_W'(OP_ADC_I);
    localparam logic [DATA_W-1:0] I_LDA_A = DATA_W'(OP_LDA_A);
    localparam logic [DATA_W-1:0] I_STA_A = DATA_W'(OP_STA_A);
    localparam logic [DATA_W-1:0] I_JMP_A = DATA_W'(OP_JMP_A);

    state_t              state_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [ADDR_W-1:0]   pc_d;
    logic [ADDR_W-1:0]   ea_mem_d;
    logic [ADDR_W-1:0]   ea_jmp_d;
    logic [DATA_W-1:0]   acc_q;
    logic [DATA_W-1:0]   ir_q;
    logic [DATA_W-1:0]   lo_q;
    logic [DATA_W-1:0]   hi_q;
    logic                n_q;
    logic                z_q;
    logic                c_q;
    logic                halted_q;
    logic                illegal_q;

    logic                alu_add;
    logic [DATA_W-1:0]   alu_res;
    logic                alu_n;
    logic                alu_z;
    logic                alu_c;

    assign pc_d     = pc_q + ADDR_W'(1);
    assign ea_mem_d = ADDR_W'({hi_q, lo_q});
    // JMP takes the high byte straight off the bus to save a cycle
    assign ea_jmp_d = ADDR_W'({mem_rdata, lo_q});
    assign alu_add  = (state_q == S_OP1) && (ir_q == I_ADC_I);

    cpu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a_i   (acc_q),
        .b_i   (mem_rdata),
        .cin_i (c_q),
        .add_i (alu_add),
        .res_o (alu_res),
        .n_o   (alu_n),
        .z_o   (alu_z),
        .c_o   (alu_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_VEC;
            acc_q     <= '0;
            ir_q      <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
            n_q       <= 1'b0;
            z_q       <= 1'b0;
            c_q       <= 1'b0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (run) begin
                        pc_q    <= pc_d;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    ir_q <= mem_rdata;
                    case (mem_rdata)
                        I_NOP: state_q <= S_FETCH;
                        I_CLC: begin
                            c_q     <= 1'b0;
                            state_q <= S_FETCH;
                        end
                        I_SEC: begin
                            c_q     <= 1'b1;
                            state_q <= S_FETCH;
                        end
                        I_BRK: begin
                            halted_q <= 1'b1;
                            state_q  <= S_HALT;
                        end
                        I_LDA_I, I_ADC_I, I_LDA_A, I_STA_A, I_JMP_A: begin
                            pc_q    <= pc_d;
                            state_q <= S_OP1;
                        end
                        default: begin
                            halted_q  <= 1'b1;
                            illegal_q <= 1'b1;
                            state_q   <= S_HALT;
                        end
                    endcase
                end
                S_OP1: begin
                    case (ir_q)
                        I_LDA_I, I_ADC_I: begin
                            acc_q   <= alu_res;
                            n_q     <= alu_n;
                            z_q     <= alu_z;
                            c_q     <= alu_c;
                            state_q <= S_FETCH;
                        end
                        default: begin
                            lo_q    <= mem_rdata;
                            pc_q    <= pc_d;
                            state_q <= S_OP2;
                        end
                    endcase
                end
                S_OP2: begin
                    hi_q <= mem_rdata;
                    if (ir_q == I_JMP_A) begin
                        pc_q    <= ea_jmp_d;
                        state_q <= S_FETCH;
                    end else begin
                        state_q <= S_MEM;
                    end
                end
                S_MEM: begin
                    state_q <= (ir_q == I_LDA_A) ? S_LOAD : S_FETCH;
                end
                S_LOAD: begin
                    acc_q   <= alu_res;
                    n_q     <= alu_n;
                    z_q     <= alu_z;
                    state_q <= S_FETCH;
                end
                S_HALT: state_q <= S_HALT;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    assign mem_addr  = (state_q == S_MEM) ? ea_mem_d : pc_q;
    assign mem_we    = (state_q == S_MEM) && (ir_q == I_STA_A);
    assign mem_wdata = acc_q;
    assign state     = state_q;
    assign pc        = pc_q;
    assign acc       = acc_q;
    assign flags     = {n_q, z_q, c_q};
    assign halted    = halted_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_cpu_core_seq.sv
// Self-checking bench for cpu_core_seq: vector table, corner sequences,
// and a random program checked against an instruction-level model.
module tb_cpu_core_seq;
    import cpu_core_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic [7:0]  mem_rdata = 8'h00;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    state_t      state;
    logic [15:0] pc;
    logic [7:0]  acc;
    logic [2:0]  flags;
    logic        halted;
    logic        illegal;

    cpu_core_seq #(
        .DATA_W    (8),
        .ADDR_W    (16),
        .RESET_VEC (16'h0200)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .state     (state),
        .pc        (pc),
        .acc       (acc),
        .flags     (flags),
        .halted    (halted),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:65535];
    logic [7:0]  mm  [0:65535];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          we_cnt = 0;
    logic [15:0] we_addr = 16'h0;
    logic [7:0]  we_data = 8'h0;

    logic [15:0] m_pc;
    logic [7:0]  m_a;
    logic        m_n, m_z, m_c;

    typedef struct {
        logic [7:0] a0;
        logic       c0;
        logic [7:0] op;
        logic [7:0] imm;
        logic [7:0] ea;
        logic [2:0] ef;
        int         ecyc;
    } vec_t;
    vec_t vt [9];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Memory model: write and read use the address seen before the edge;
    // read data appears just after the edge.
    task automatic tick();
        logic [7:0] r;
        if (mem_we === 1'b1) begin
            mem[mem_addr] = mem_wdata;
            we_cnt++;
            we_addr = mem_addr;
            we_data = mem_wdata;
        end
        r = mem[mem_addr];
        @(posedge clk);
        #1;
        mem_rdata = r;
    endtask

    task automatic do_reset();
        run = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        mem[a] = d;
        mm[a]  = d;
    endtask

    task automatic step(output int cyc);
        run = 1'b1;
        tick();
        cyc = 1;
        run = 1'b0;
        while (state != S_FETCH && state != S_HALT && cyc < 20) begin
            tick();
            cyc++;
        end
        if (cyc >= 20) begin
            n_cmp++;
            n_fail++;
            $display("FAIL step_timeout: state %0d after %0d cycles",
                     state, cyc);
        end
    endtask

    task automatic m_set_a(input logic [7:0] v);
        m_a = v;
        m_n = v[7];
        m_z = (v == 8'h00);
    endtask

    task automatic model_exec(output int cyc);
        logic [7:0]  op;
        logic [8:0]  s;
        logic [15:0] ea;
        op = mm[m_pc];
        m_pc = m_pc + 16'd1;
        cyc = 2;
        case (op)
            8'h18: m_c = 1'b0;
            8'h38: m_c = 1'b1;
            8'hA9: begin
                m_set_a(mm[m_pc]);
                m_pc = m_pc + 16'd1;
                cyc = 3;
            end
            8'h69: begin
                s = {1'b0, m_a} + {1'b0, mm[m_pc]} + {8'h00, m_c};
                m_c = s[8];
                m_set_a(s[7:0]);
                m_pc = m_pc + 16'd1;
                cyc = 3;
            end
            8'hAD, 8'h8D, 8'h4C: begin
                ea = {mm[m_pc + 16'd1], mm[m_pc]};
                m_pc = m_pc + 16'd2;
                if (op == 8'h4C) begin
                    m_pc = ea;
                    cyc = 4;
                end else if (op == 8'h8D) begin
                    mm[ea] = m_a;
                    cyc = 5;
                end else begin
                    m_set_a(mm[ea]);
                    cyc = 6;
                end
            end
            default: cyc = 2;
        endcase
    endtask

    initial begin
        int          c;
        int          w0;
        logic [7:0]  ops [7];
        logic [15:0] p;

        vt[0] = '{8'hFF, 1'b0, 8'h69, 8'h01, 8'h00, 3'b011, 3};
        vt[1] = '{8'h10, 1'b1, 8'h69, 8'h20, 8'h31, 3'b000, 3};
        vt[2] = '{8'h7F, 1'b0, 8'h69, 8'h01, 8'h80, 3'b100, 3};
        vt[3] = '{8'h80, 1'b1, 8'h69, 8'hFF, 8'h80, 3'b101, 3};
        vt[4] = '{8'h00, 1'b1, 8'hA9, 8'h00, 8'h00, 3'b011, 3};
        vt[5] = '{8'h01, 1'b0, 8'hA9, 8'hC3, 8'hC3, 3'b100, 3};
        vt[6] = '{8'h00, 1'b0, 8'hEA, 8'hEA, 8'h00, 3'b010, 2};
        vt[7] = '{8'h55, 1'b0, 8'h38, 8'hEA, 8'h55, 3'b001, 2};
        vt[8] = '{8'hAA, 1'b1, 8'h18, 8'hEA, 8'hAA, 3'b100, 2};

        #1;
        do_reset();
        chk("rst_pc", pc, 16'h0200);
        chk("rst_acc", acc, 8'h00);
        chk("rst_flags", flags, 3'b000);
        chk("rst_state", state, S_FETCH);
        chk("rst_halted", {halted, illegal}, 2'b00);
        chk("rst_we", we_cnt, 0);

        for (int i = 0; i < 9; i++) begin
            do_reset();
            poke(16'h0200, 8'hA9);
            poke(16'h0201, vt[i].a0);
            poke(16'h0202, vt[i].c0 ? 8'h38 : 8'h18);
            poke(16'h0203, vt[i].op);
            poke(16'h0204, vt[i].imm);
            step(c);
            chk("vec_lda_cyc", c, 3);
            step(c);
            chk("vec_carry_cyc", c, 2);
            step(c);
            chk($sformatf("vec%0d_cyc", i), c, vt[i].ecyc);
            chk($sformatf("vec%0d_acc", i), acc, vt[i].ea);
            chk($sformatf("vec%0d_flags", i), flags, vt[i].ef);
        end

        do_reset();
        w0 = we_cnt;
        poke(16'h0200, 8'hA9); poke(16'h0201, 8'h5A);
        poke(16'h0202, 8'h8D); poke(16'h0203, 8'h34); poke(16'h0204, 8'h12);
        poke(16'h0205, 8'hA9); poke(16'h0206, 8'h00);
        poke(16'h0207, 8'hAD); poke(16'h0208, 8'h34); poke(16'h0209, 8'h12);
        poke(16'h1234, 8'h00);
        step(c);
        step(c);
        chk("sta_cyc", c, 5);
        chk("sta_we_cnt", we_cnt - w0, 1);
        chk("sta_addr", we_addr, 16'h1234);
        chk("sta_data", we_data, 8'h5A);
        step(c);
        chk("lda0_z", flags, 3'b010);
        step(c);
        chk("ldaabs_cyc", c, 6);
        chk("ldaabs_acc", acc, 8'h5A);
        chk("ldaabs_flags", flags, 3'b000);
        chk("ldaabs_pc", pc, 16'h020A);

        do_reset();
        poke(16'h0200, 8'h4C); poke(16'h0201, 8'hFF); poke(16'h0202, 8'hFF);
        poke(16'hFFFF, 8'hEA);
        poke(16'h0000, 8'h4C); poke(16'h0001, 8'h00); poke(16'h0002, 8'h30);
        step(c);
        chk("jmp_cyc", c, 4);
        chk("jmp_pc", pc, 16'hFFFF);
        step(c);
        chk("wrap_pc", pc, 16'h0000);
        step(c);
        chk("jmp2_cyc", c, 4);
        chk("jmp2_pc", pc, 16'h3000);

        do_reset();
        poke(16'hFFFF, 8'hA9);
        poke(16'h0000, 8'h77);
        step(c);
        step(c);
        chk("straddle_acc", acc, 8'h77);
        chk("straddle_pc", pc, 16'h0001);

        do_reset();
        poke(16'h0200, 8'hFF);
        step(c);
        chk("ill_state", state, S_HALT);
        chk("ill_bits", {halted, illegal}, 2'b11);
        run = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        run = 1'b0;
        chk("ill_pc_frozen", pc, 16'h0201);
        chk("ill_state2", state, S_HALT);
        do_reset();
        chk("ill_cleared", {halted, illegal}, 2'b00);
        poke(16'h0200, 8'h00);
        step(c);
        chk("brk_bits", {halted, illegal}, 2'b10);
        chk("brk_state", state, S_HALT);
        do_reset();
        chk("brk_cleared", {halted, illegal, state}, {2'b00, S_FETCH});

        do_reset();
        poke(16'h0200, 8'hAD); poke(16'h0201, 8'h34); poke(16'h0202, 8'h12);
        poke(16'h1234, 8'h99);
        step(c);
        chk("rundrop_cyc", c, 6);
        for (int k = 0; k < 5; k++) tick();
        chk("rundrop_state", state, S_FETCH);
        chk("rundrop_pc", pc, 16'h0203);
        chk("rundrop_acc", acc, 8'h99);

        do_reset();
        poke(16'h0200, 8'hA9); poke(16'h0201, 8'h11);
        poke(16'h0202, 8'h8D); poke(16'h0203, 8'h00); poke(16'h0204, 8'h50);
        poke(16'h5000, 8'h00);
        step(c);
        w0 = we_cnt;
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        tick();
        chk("op2_reached", state, S_OP2);
        rst = 1'b1;
        tick();
        chk("midrst_state", state, S_FETCH);
        chk("midrst_pc", pc, 16'h0200);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("midrst_no_we", we_cnt - w0, 0);
        chk("midrst_mem", mem[16'h5000], 8'h00);

        ops[0] = 8'hEA; ops[1] = 8'h18; ops[2] = 8'h38; ops[3] = 8'hA9;
        ops[4] = 8'h69; ops[5] = 8'hAD; ops[6] = 8'h8D;
        for (int k = 0; k < 16; k++) poke(16'h4000 + 16'(k), 8'($urandom));
        p = 16'h0200;
        for (int k = 0; k < 40; k++) begin
            logic [7:0] o;
            o = ops[$urandom_range(0, 6)];
            poke(p, o);
            p = p + 16'd1;
            if (o == 8'hA9 || o == 8'h69) begin
                poke(p, 8'($urandom));
                p = p + 16'd1;
            end else if (o == 8'hAD || o == 8'h8D) begin
                poke(p, 8'($urandom_range(0, 15)));
                poke(p + 16'd1, 8'h40);
                p = p + 16'd2;
            end
        end
        do_reset();
        m_pc = 16'h0200;
        m_a = 8'h00;
        m_n = 1'b0; m_z = 1'b0; m_c = 1'b0;
        for (int k = 0; k < 40; k++) begin
            int mc;
            model_exec(mc);
            step(c);
            chk($sformatf("rnd%0d_cyc", k), c, mc);
            chk($sformatf("rnd%0d_acc", k), acc, m_a);
            chk($sformatf("rnd%0d_flags", k), flags, {m_n, m_z, m_c});
            chk($sformatf("rnd%0d_pc", k), pc, m_pc);
        end
        for (int k = 0; k < 16; k++)
            chk($sformatf("rnd_mem%0d", k), mem[16'h4000 + 16'(k)],
                mm[16'h4000 + 16'(k)]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
